// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the BCD-to-binary converter.
//               Holds the converter state encoding, digit geometry, shift
//               count and a helper that flags non-decimal nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int N_DIGITS     = 4;
    localparam int DIGIT_W      = 4;
    localparam int SHIFT_CYCLES = 16;
    localparam int CNT_W        = $clog2(SHIFT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A BCD digit is only legal in the range 0..9.
    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
        return (digit > DIGIT_W'(9));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_nibble_adjust.sv
`default_nettype none
// ============================================================================
// Module      : bcd_nibble_adjust
// Description : Combinational correction for one BCD digit after a right
//               shift: a digit of 8 or more had a "ten" shifted into it and
//               is reduced by 3 so the nibble stays a valid decimal digit.
// Ports       : i_nibble - digit after the right shift
//               o_nibble - corrected digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_nibble_adjust #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] i_nibble,
    output logic [DIGIT_W-1:0] o_nibble
);

    assign o_nibble = (i_nibble >= DIGIT_W'(8)) ? (i_nibble - DIGIT_W'(3)) : i_nibble;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_bin
// Description : Sequential BCD-to-binary converter (reverse double dabble).
//               A start in IDLE captures bcd_in; the {bcd, bin} pair is then
//               shifted right once per cycle for SHIFT_CYCLES cycles with a
//               per-digit "-3 if >= 8" correction. Inputs holding a digit
//               above 9 skip the shifting and report error with a zero result.
// Ports       : clk     - system clock, rising edge
//               reset   - synchronous active-low reset
//               start   - conversion request, honoured only in IDLE
//               bcd_in  - packed BCD digits, most significant digit on top
//               bin_out - registered binary result, held between conversions
//               done    - one-cycle pulse: bin_out and error are valid
//               busy    - conversion in progress (state is not IDLE)
//               error   - captured digit set contained a nibble above 9
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [N_DIGITS*bcd_pkg::DIGIT_W-1:0] bcd_in,
    output logic [BIN_W-1:0]                     bin_out,
    output logic                                 done,
    output logic                                 busy,
    output logic                                 error
);

    import bcd_pkg::*;

    localparam int              c_BCD_W    = N_DIGITS * DIGIT_W;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(SHIFT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] w_bcd_shift;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin_out;
    logic               r_error;
    logic               r_done;
    logic               w_bcd_invalid;
    logic               w_last_shift;

    // One combined right shift of {bcd, bin}: the bcd LSB enters bin at the top.
    assign w_bcd_shift  = r_bcd >> 1;
    assign w_bin_shift  = {r_bcd[0], r_bin[BIN_W-1:1]};
    assign w_last_shift = (r_cnt == c_LAST_CNT);

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            bcd_nibble_adjust #(
                .DIGIT_W (DIGIT_W)
            ) u_adj (
                .i_nibble (w_bcd_shift[gi*DIGIT_W +: DIGIT_W]),
                .o_nibble (w_bcd_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    always_comb begin
        w_bcd_invalid = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_invalid(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
                w_bcd_invalid = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_bcd_invalid ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_shift) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // done is registered on the DONE->IDLE edge, so the pulse appears in the
    // cycle after the conversion leaves DONE and busy has already dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_bin_out <= '0;
            r_error   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_bcd_invalid) begin
                            r_bin_out <= '0;
                            r_error   <= 1'b1;
                        end else begin
                            r_bcd <= bcd_in;
                            r_bin <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_shift;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_shift) begin
                        r_bin_out <= w_bin_shift;
                        r_error   <= 1'b0;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bin_out = r_bin_out;
    assign error   = r_error;
    assign done    = r_done;
    assign busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_to_bin
// Description : Self-checking bench for bcd_to_bin: reset state, a table of
//               directed conversions, start/bcd_in interference during a
//               conversion, mid-conversion reset and a strided sweep of
//               0..9999 against an integer reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bcd_in;
    logic [15:0] bin_out;
    logic        done;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;

    bcd_to_bin #(
        .N_DIGITS (4),
        .BIN_W    (16)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .done    (done),
        .busy    (busy),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] bin;
        logic        err;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Caller is positioned 1 ns after a rising edge. Pulses start for one
    // cycle and waits (bounded) for done. lat counts edges after the start
    // edge; busy_cyc counts cycles with busy high.
    task automatic convert(input logic [15:0] bcd, output int lat, output int busy_cyc);
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = -1;
        busy_cyc = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cyc++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    vec_t vecs[12];
    int   lat;
    int   bcyc;
    int   ndone;
    int   first_lat;
    logic [15:0] first_bin;

    initial begin
        vecs[0]  = '{16'h9999, 16'h270F, 1'b0, 17};
        vecs[1]  = '{16'h1234, 16'h04D2, 1'b0, 17};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 17};
        vecs[3]  = '{16'h0001, 16'h0001, 1'b0, 17};
        vecs[4]  = '{16'h12A4, 16'h0000, 1'b1, 1};
        vecs[5]  = '{16'h0042, 16'h002A, 1'b0, 17};
        vecs[6]  = '{16'h5000, 16'h1388, 1'b0, 17};
        vecs[7]  = '{16'h0255, 16'h00FF, 1'b0, 17};
        vecs[8]  = '{16'hF000, 16'h0000, 1'b1, 1};
        vecs[9]  = '{16'h0009, 16'h0009, 1'b0, 17};
        vecs[10] = '{16'h1000, 16'h03E8, 1'b0, 17};
        vecs[11] = '{16'h8765, 16'h223D, 1'b0, 17};

        reset  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bin_out", 32'(bin_out), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_error", 32'(error), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, back to back: each start is issued in the done cycle.
        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bcd, lat, bcyc);
            check($sformatf("vec%0d_bin", i), 32'(bin_out), 32'(vecs[i].bin));
            check($sformatf("vec%0d_err", i), 32'(error), 32'(vecs[i].err));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i), 32'(bcyc), 32'(vecs[i].lat));
        end

        // Start pulses and bcd_in changes during a conversion are ignored.
        start  = 1'b1;
        bcd_in = 16'h5000;
        @(posedge clk);
        #1;
        start     = 1'b0;
        ndone     = 0;
        first_lat = -1;
        first_bin = 16'hDEAD;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 3 || k == 10) ? 1'b1 : 1'b0;
            if (k == 5) bcd_in = 16'h1111;
            @(posedge clk);
            #1;
            if (k == 8) begin
                check("hold_bin_mid", 32'(bin_out), 32'h223D);
                check("busy_mid", 32'(busy), 32'h1);
            end
            if (done) begin
                ndone++;
                if (first_lat < 0) begin
                    first_lat = k;
                    first_bin = bin_out;
                end
            end
        end
        check("ignore_ndone", 32'(ndone), 32'h1);
        check("ignore_lat", 32'(first_lat), 32'd17);
        check("ignore_bin", 32'(first_bin), 32'h1388);

        // Error is held through a later conversion until it completes; a
        // reset in the middle aborts with no done pulse.
        convert(16'hF000, lat, bcyc);
        check("err_set", 32'(error), 32'h1);
        start  = 1'b1;
        bcd_in = 16'h9999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("err_hold_mid", 32'(error), 32'h1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_bin", 32'(bin_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_error", 32'(error), 32'h0);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'h0);
        convert(16'h0255, lat, bcyc);
        check("after_abort_bin", 32'(bin_out), 32'h00FF);
        check("after_abort_lat", 32'(lat), 32'd17);

        // Strided sweep of the decimal range against the integer value.
        for (int v = 0; v <= 9999; v += 37) begin
            convert(to_bcd(v), lat, bcyc);
            check($sformatf("sweep%0d_bin", v), 32'(bin_out), 32'(v));
            check($sformatf("sweep%0d_err", v), 32'(error), 32'h0);
            check($sformatf("sweep%0d_busy", v), 32'(bcyc), 32'd17);
        end
        convert(to_bcd(9999), lat, bcyc);
        check("sweep9999_bin", 32'(bin_out), 32'd9999);
        check("sweep9999_top", 32'(bin_out[15:14]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
